// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: shift/rotate/load/clear with a framing counter
// that pulses USR_DONE every WIDTH shifts. Define USR_ARITH_SHIFT_EN to enable MODE 111 = ASR.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          USR_CLK,
  input  logic                          USR_RST,
  input  logic                          USR_EN,
  input  logic [2:0]                    USR_MODE,
  input  logic                          USR_SIN_R,
  input  logic                          USR_SIN_L,
  input  logic [WIDTH-1:0]              USR_PIN,
  output logic [WIDTH-1:0]              USR_Q,
  output logic                          USR_SOUT_R,
  output logic                          USR_SOUT_L,
  output logic [$clog2(WIDTH)-1:0]      USR_CNT,
  output logic                          USR_DONE
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_LOAD = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_CLR  = 3'b110,
    M_ASR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             advance;
  mode_e            mode;

  assign mode = mode_e'(USR_MODE);

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    advance = 1'b0;
    if (USR_EN) begin
      case (mode)
        M_HOLD: ;
        M_SHR: begin
          q_d     = {USR_SIN_R, q_q[WIDTH-1:1]};
          advance = 1'b1;
        end
        M_SHL: begin
          q_d     = {q_q[WIDTH-2:0], USR_SIN_L};
          advance = 1'b1;
        end
        M_LOAD: begin
          q_d   = USR_PIN;
          cnt_d = '0;
        end
        M_ROR: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          advance = 1'b1;
        end
        M_ROL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          advance = 1'b1;
        end
        M_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        M_ASR: begin
`ifdef USR_ARITH_SHIFT_EN
          q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          advance = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    // Any shift-class operation counts toward the frame, regardless of direction.
    if (advance) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge USR_CLK) begin
    if (USR_RST) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign USR_Q      = q_q;
  assign USR_CNT    = cnt_q;
  assign USR_DONE   = done_q;
  assign USR_SOUT_R = q_q[0];
  assign USR_SOUT_L = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expected values.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [7:0] pin;
  logic [7:0] q;
  logic       sout_r, sout_l, done;
  logic [2:0] cnt;

  int passes = 0;
  int total  = 0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .USR_CLK   (clk),
    .USR_RST   (rst),
    .USR_EN    (en),
    .USR_MODE  (mode),
    .USR_SIN_R (sin_r),
    .USR_SIN_L (sin_l),
    .USR_PIN   (pin),
    .USR_Q     (q),
    .USR_SOUT_R(sout_r),
    .USR_SOUT_L(sout_l),
    .USR_CNT   (cnt),
    .USR_DONE  (done)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic sr, input logic sl, input logic [7:0] p);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq,
                             input logic [2:0] ec, input logic ed);
    check({tag, ".q"},    {24'd0, q},    {24'd0, eq});
    check({tag, ".cnt"},  {29'd0, cnt},  {29'd0, ec});
    check({tag, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  logic [7:0] shr_bits;
  logic [7:0] shr_q [8];
  logic [7:0] abort_q;
  logic [7:0] fill_q;

  initial begin
    shr_bits = 8'b0100_1101;  // bit i = SIN_R of shift i: 1,0,1,1,0,0,1,0
    shr_q = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h9A, 8'h4D};

    step(1, 0, 3'b000, 0, 0, 8'h00);
    step(1, 0, 3'b000, 0, 0, 8'h00);
    check_state("reset", 8'h00, 3'd0, 1'b0);

    step(0, 1, 3'b011, 0, 0, 8'hA5);
    check_state("load_a5", 8'hA5, 3'd0, 1'b0);
    step(1, 1, 3'b001, 1, 1, 8'hFF);
    check_state("rst_over_a5", 8'h00, 3'd0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'b001, shr_bits[i], 0, 8'h00);
      check_state($sformatf("shr%0d", i + 1), shr_q[i], 3'((i + 1) % 8), i == 7);
      check($sformatf("shr%0d.sout_r", i + 1), {31'd0, sout_r}, {31'd0, shr_q[i][0]});
    end
    step(0, 1, 3'b000, 0, 0, 8'h00);
    check_state("hold_after_frame", 8'h4D, 3'd0, 1'b0);

    step(0, 1, 3'b011, 0, 0, 8'h81);
    check_state("load_81", 8'h81, 3'd0, 1'b0);
    step(0, 1, 3'b101, 0, 0, 8'h00);
    check_state("rol1", 8'h03, 3'd1, 1'b0);
    step(0, 1, 3'b100, 0, 0, 8'h00);
    check_state("ror1", 8'h81, 3'd2, 1'b0);
    step(0, 1, 3'b100, 0, 0, 8'h00);
    check_state("ror2", 8'hC0, 3'd3, 1'b0);
    check("c0.sout_l", {31'd0, sout_l}, 32'd1);
    check("c0.sout_r", {31'd0, sout_r}, 32'd0);

    step(0, 1, 3'b011, 0, 0, 8'hF0);
    step(0, 1, 3'b010, 0, 1, 8'h00);
    step(0, 1, 3'b010, 0, 1, 8'h00);
    step(0, 1, 3'b010, 0, 1, 8'h00);
    check_state("shl3", 8'h87, 3'd3, 1'b0);
    step(0, 1, 3'b011, 0, 0, 8'h11);
    check_state("load_11_abort", 8'h11, 3'd0, 1'b0);
    abort_q = 8'h11;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 3'b001, 0, 0, 8'h00);
      abort_q = abort_q >> 1;
      check_state($sformatf("abort_shr%0d", i + 1), abort_q, 3'(i + 1), 1'b0);
    end
    step(0, 1, 3'b001, 0, 0, 8'h00);
    check_state("abort_shr8", 8'h00, 3'd0, 1'b1);

    step(0, 1, 3'b011, 0, 0, 8'h3C);
    fill_q = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 3'b001, 1, 0, 8'h00);
      fill_q = {1'b1, fill_q[7:1]};
    end
    check_state("shr6", 8'hFC, 3'd6, 1'b0);
    check("shr6.model", {24'd0, fill_q}, {24'd0, q});
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3'b001, 0, 1, 8'h55);
      check_state($sformatf("en0_%0d", i), 8'hFC, 3'd6, 1'b0);
    end
    step(0, 1, 3'b001, 1, 0, 8'h00);
    check_state("resume7", 8'hFE, 3'd7, 1'b0);
    step(0, 1, 3'b001, 1, 0, 8'h00);
    check_state("resume8", 8'hFF, 3'd0, 1'b1);
    step(0, 0, 3'b000, 0, 0, 8'h00);
    check_state("en0_clears_done", 8'hFF, 3'd0, 1'b0);

    step(0, 1, 3'b011, 0, 0, 8'hAA);
    step(0, 1, 3'b001, 0, 0, 8'h00);
    step(0, 1, 3'b001, 0, 0, 8'h00);
    step(0, 1, 3'b001, 0, 0, 8'h00);
    check_state("pre_clr", 8'h15, 3'd3, 1'b0);
    step(0, 1, 3'b110, 1, 1, 8'hFF);
    check_state("clr", 8'h00, 3'd0, 1'b0);

    step(0, 1, 3'b101, 0, 0, 8'h00);
    step(0, 1, 3'b101, 0, 0, 8'h00);
    step(1, 1, 3'b101, 0, 0, 8'h00);
    check_state("rst_midframe", 8'h00, 3'd0, 1'b0);

    step(0, 1, 3'b011, 0, 0, 8'h90);
    step(0, 1, 3'b111, 0, 0, 8'h00);
`ifdef USR_ARITH_SHIFT_EN
    check_state("mode7_asr", 8'hC8, 3'd1, 1'b0);
`else
    check_state("mode7_hold", 8'h90, 3'd0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
